// File: rtl/bam_pkg.sv
// Shared types and helpers for the sequential unsigned broken-array multiplier.
// Holds the FSM state enum, cut-register width helpers and the column-cut mask.
package bam_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int BAM_N_DEF    = 8;
    localparam int BAM_MASK_MAX = 64;

    // Row cut ranges 0..N inclusive; column cut ranges 0..2N-1.
    function automatic int cfg_h_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int cfg_v_w(input int n);
        return $clog2(2 * n);
    endfunction

    // Bit i set iff i >= k and i < n; callers size-cast to their own N.
    function automatic logic [BAM_MASK_MAX-1:0] row_mask(input int n, input int k);
        logic [BAM_MASK_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < BAM_MASK_MAX; i++) begin
            m[i] = (i < n) && (i >= k);
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_u_bam_mul_row_add.sv
// Combinational single-row step of the broken-array multiplier:
// acc + ((a & mask(V-j)) << j) when b[j] is set, acc otherwise.
module seq_u_bam_mul_row_add
    import bam_pkg::*;
#(
    parameter int N  = BAM_N_DEF,
    parameter int HW = cfg_h_w(BAM_N_DEF),
    parameter int VW = cfg_v_w(BAM_N_DEF)
) (
    input  logic [N-1:0]   a_i,
    input  logic           b_bit_i,
    input  logic [HW-1:0]  j_i,
    input  logic [VW-1:0]  v_i,
    input  logic [2*N-1:0] acc_i,
    output logic [2*N-1:0] acc_o
);

    int             k;
    logic [N-1:0]   mask;
    logic [2*N-1:0] row;

    // NOTE: every combinational output gets a value before any branch, so no latch can be inferred.
    always_comb begin
        k     = int'(v_i) - int'(j_i);
        mask  = N'(row_mask(N, k));
        row   = {{N{1'b0}}, a_i & mask} << j_i;
        acc_o = acc_i;
        if (b_bit_i) begin
            acc_o = acc_i + row;
        end
    end

endmodule

// File: rtl/seq_u_bam_mul.sv
// Sequential unsigned broken-array multiplier, one partial-product row per cycle,
// with run-time row (H) and column (V) cuts. Optional macro: BAM_EARLY_TERM_EN.
module seq_u_bam_mul
    import bam_pkg::*;
#(
    parameter int  N     = BAM_N_DEF,
    parameter int  H_RST = 0,
    parameter int  V_RST = 0,
    localparam int HW    = cfg_h_w(N),
    localparam int VW    = cfg_v_w(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [HW-1:0]  cfg_h,
    input  logic           cfg_h_we,
    input  logic [VW-1:0]  cfg_v,
    input  logic           cfg_v_we,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p,
    output logic           busy
);

    state_e         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [HW-1:0]  j_q, j_d;
    logic [VW-1:0]  v_q, v_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [HW-1:0]  h_cfg_q, h_cfg_d;
    logic [VW-1:0]  v_cfg_q, v_cfg_d;

    logic           b_bit;
    logic           last_row;
    logic [2*N-1:0] row_sum;

    assign b_bit = |(b_q & (N'(1) << j_q));

    seq_u_bam_mul_row_add #(
        .N  (N),
        .HW (HW),
        .VW (VW)
    ) u_row_add (
        .a_i     (a_q),
        .b_bit_i (b_bit),
        .j_i     (j_q),
        .v_i     (v_q),
        .acc_i   (acc_q),
        .acc_o   (row_sum)
    );

    // A row index past N-1 only happens when H >= N; it ends MUL after one empty step.
    always_comb begin
        last_row = (j_q >= HW'(N - 1));
`ifdef BAM_EARLY_TERM_EN
        last_row = last_row || (((b_q >> j_q) >> 1) == '0);
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        j_d     = j_q;
        v_d     = v_q;
        acc_d   = acc_q;
        h_cfg_d = cfg_h_we ? cfg_h : h_cfg_q;
        v_cfg_d = cfg_v_we ? cfg_v : v_cfg_q;

        unique case (state_q)
            IDLE: begin
                // Snapshot the cut registers before this cycle's write lands.
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b;
                    j_d     = h_cfg_q;
                    v_d     = v_cfg_q;
                    acc_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d = row_sum;
                if (last_row) begin
                    state_d = DONE;
                end else begin
                    j_d = j_q + HW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    // NOTE: the datapath registers are reset too, so p and acc read as zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            j_q     <= '0;
            v_q     <= '0;
            acc_q   <= '0;
            h_cfg_q <= HW'(H_RST);
            v_cfg_q <= VW'(V_RST);
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            j_q     <= j_d;
            v_q     <= v_d;
            acc_q   <= acc_d;
            h_cfg_q <= h_cfg_d;
            v_cfg_q <= v_cfg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign p         = out_valid ? acc_q : '0;

endmodule

// File: tb/tb_seq_u_bam_mul.sv
// Self-checking bench for seq_u_bam_mul (N=8) against a sum-of-terms reference model.
// Expected latency follows BAM_EARLY_TERM_EN when the bench is compiled with it.
module tb_seq_u_bam_mul;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     cfg_h;
    logic           cfg_h_we;
    logic [3:0]     cfg_v;
    logic           cfg_v_we;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] p;
    logic           busy;

    int errors = 0;
    int checks = 0;
    int cur_h  = 0;
    int cur_v  = 0;

    seq_u_bam_mul #(
        .N     (N),
        .H_RST (0),
        .V_RST (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_h     (cfg_h),
        .cfg_h_we  (cfg_h_we),
        .cfg_v     (cfg_v),
        .cfg_v_we  (cfg_v_we),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: sum of a[i]*b[j]*2^(i+j) over kept terms (j >= h, i+j >= v).
    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] ra, input logic [N-1:0] rb,
                                               input int h, input int v);
        logic [2*N-1:0] s;
        s = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                if (ra[i] && rb[j] && (j >= h) && (i + j >= v)) begin
                    s = s + ((2*N)'(1) << (i + j));
                end
            end
        end
        return s;
    endfunction

    function automatic int exp_lat(input logic [N-1:0] rb, input int h);
`ifdef BAM_EARLY_TERM_EN
        int msb;
        msb = -1;
        for (int i = 0; i < N; i++) begin
            if (rb[i]) msb = i;
        end
        if (h >= N || msb < h) return 1;
        return msb - h + 1;
`else
        if (h >= N) return 1;
        return N - h;
`endif
    endfunction

    task automatic start_op(input logic [N-1:0] ia, input logic [N-1:0] ib);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        a        = ia;
        b        = ib;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic do_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                         output logic [2*N-1:0] op, output int lat);
        start_op(ia, ib);
        wait_done(lat);
        op = p;
        finish_op();
    endtask

    task automatic set_cfg(input int h, input int v);
        cfg_h    = 4'(h);
        cfg_v    = 4'(v);
        cfg_h_we = 1'b1;
        cfg_v_we = 1'b1;
        @(posedge clk); #1;
        cfg_h_we = 1'b0;
        cfg_v_we = 1'b0;
        cur_h    = h;
        cur_v    = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== '0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b p=%0d, want 1 0 0 0",
                     in_ready, out_valid, busy, p);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b busy=%b, want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_exact();
        logic [2*N-1:0] op;
        int lat;
        set_cfg(0, 0);
        do_op(8'd200, 8'd100, op, lat);
        checks++;
        if (op !== 16'd20000) begin
            errors++;
            $display("FAIL exact_200x100: p=%0d want 20000", op);
        end
        checks++;
        if (lat !== exp_lat(8'd100, 0)) begin
            errors++;
            $display("FAIL exact_latency: got %0d want %0d", lat, exp_lat(8'd100, 0));
        end
    endtask

    task automatic test_cut();
        logic [2*N-1:0] op;
        int lat;
        set_cfg(1, 10);
        do_op(8'd255, 8'd255, op, lat);
        checks++;
        if (op !== 16'd58368) begin
            errors++;
            $display("FAIL cut_h1_v10: p=%0d want 58368", op);
        end
        checks++;
        if (op[9:0] !== 10'd0) begin
            errors++;
            $display("FAIL cut_low_bits: p[9:0]=%0d want 0", op[9:0]);
        end
        checks++;
        if (lat !== exp_lat(8'd255, 1)) begin
            errors++;
            $display("FAIL cut_latency: got %0d want %0d", lat, exp_lat(8'd255, 1));
        end
        set_cfg(0, 15);
        do_op(8'd255, 8'd255, op, lat);
        checks++;
        if (op !== '0 || lat !== exp_lat(8'd255, 0)) begin
            errors++;
            $display("FAIL cut_v15: p=%0d lat=%0d want 0 and %0d", op, lat, exp_lat(8'd255, 0));
        end
    endtask

    task automatic test_cfg_midop();
        logic [2*N-1:0] op;
        int lat;
        set_cfg(0, 0);
        fork
            do_op(8'd255, 8'd255, op, lat);
            begin
                repeat (3) @(posedge clk);
                #2;
                cfg_h    = 4'd9;
                cfg_h_we = 1'b1;
                @(posedge clk); #2;
                cfg_h_we = 1'b0;
            end
        join
        cur_h = 9;
        checks++;
        if (op !== 16'd65025 || lat !== exp_lat(8'd255, 0)) begin
            errors++;
            $display("FAIL midop_cfg_inflight: p=%0d lat=%0d want 65025 and %0d",
                     op, lat, exp_lat(8'd255, 0));
        end
        do_op(8'd255, 8'd255, op, lat);
        checks++;
        if (op !== '0 || lat !== 1) begin
            errors++;
            $display("FAIL midop_cfg_next_h9: p=%0d lat=%0d want 0 and 1", op, lat);
        end
        set_cfg(0, 0);
        fork
            do_op(8'd173, 8'd219, op, lat);
            begin
                cfg_h    = 4'd4;
                cfg_h_we = 1'b1;
                @(posedge clk); #1;
                cfg_h_we = 1'b0;
            end
        join
        cur_h = 4;
        checks++;
        if (op !== ref_mul(8'd173, 8'd219, 0, 0) || lat !== exp_lat(8'd219, 0)) begin
            errors++;
            $display("FAIL cfg_with_accept_old: p=%0d lat=%0d want %0d and %0d",
                     op, lat, ref_mul(8'd173, 8'd219, 0, 0), exp_lat(8'd219, 0));
        end
        do_op(8'd173, 8'd219, op, lat);
        checks++;
        if (op !== ref_mul(8'd173, 8'd219, 4, 0) || lat !== exp_lat(8'd219, 4)) begin
            errors++;
            $display("FAIL cfg_with_accept_new: p=%0d lat=%0d want %0d and %0d",
                     op, lat, ref_mul(8'd173, 8'd219, 4, 0), exp_lat(8'd219, 4));
        end
    endtask

    task automatic test_backpressure();
        logic [2*N-1:0] want;
        int lat;
        set_cfg(2, 3);
        want = ref_mul(8'd91, 8'd203, 2, 3);
        start_op(8'd91, 8'd203);
        wait_done(lat);
        checks++;
        if (p !== want || lat !== exp_lat(8'd203, 2)) begin
            errors++;
            $display("FAIL bp_first: p=%0d lat=%0d want %0d and %0d", p, lat, want, exp_lat(8'd203, 2));
        end
        a        = 8'd17;
        b        = 8'd33;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || p !== want || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: out_valid=%b p=%0d in_ready=%b want 1 %0d 0",
                         c, out_valid, p, in_ready, want);
            end
        end
        in_valid = 1'b0;
        finish_op();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b want 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_midop();
        logic [2*N-1:0] op;
        int lat;
        set_cfg(2, 3);
        start_op(8'd255, 8'd255);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== '0) begin
            errors++;
            $display("FAIL reset_midop: in_ready=%b out_valid=%b busy=%b p=%0d want 1 0 0 0",
                     in_ready, out_valid, busy, p);
        end
        @(posedge clk); #1;
        rst   = 1'b0;
        cur_h = 0;
        cur_v = 0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_output: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
        do_op(8'd3, 8'd5, op, lat);
        checks++;
        if (op !== 16'd15 || lat !== exp_lat(8'd5, 0)) begin
            errors++;
            $display("FAIL reset_next_op: p=%0d lat=%0d want 15 and %0d", op, lat, exp_lat(8'd5, 0));
        end
    endtask

    task automatic test_random();
        logic [2*N-1:0] op;
        logic [N-1:0]   ra;
        logic [N-1:0]   rb;
        int lat;
        for (int n = 0; n < 40; n++) begin
            if (n % 4 == 0) begin
                set_cfg(int'($urandom_range(0, 9)), int'($urandom_range(0, 15)));
            end
            ra = N'($urandom);
            rb = N'($urandom);
            if (n % 10 == 3) rb = 8'd1;
            if (n % 10 == 7) rb = 8'd128;
            do_op(ra, rb, op, lat);
            checks++;
            if (op !== ref_mul(ra, rb, cur_h, cur_v) || lat !== exp_lat(rb, cur_h)) begin
                errors++;
                $display("FAIL random_%0d a=%0d b=%0d h=%0d v=%0d: p=%0d lat=%0d want %0d and %0d",
                         n, ra, rb, cur_h, cur_v, op, lat, ref_mul(ra, rb, cur_h, cur_v),
                         exp_lat(rb, cur_h));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] op;
        int lat;
        set_cfg(0, 0);
        do_op(8'd255, 8'd1, op, lat);
        checks++;
        if (op !== 16'd255 || lat !== exp_lat(8'd1, 0)) begin
            errors++;
            $display("FAIL b2b_b1: p=%0d lat=%0d want 255 and %0d", op, lat, exp_lat(8'd1, 0));
        end
        do_op(8'd255, 8'd128, op, lat);
        checks++;
        if (op !== 16'd32640 || lat !== exp_lat(8'd128, 0)) begin
            errors++;
            $display("FAIL b2b_b128: p=%0d lat=%0d want 32640 and %0d", op, lat, exp_lat(8'd128, 0));
        end
        do_op(8'd0, 8'd0, op, lat);
        checks++;
        if (op !== '0 || lat !== exp_lat(8'd0, 0)) begin
            errors++;
            $display("FAIL b2b_zero: p=%0d lat=%0d want 0 and %0d", op, lat, exp_lat(8'd0, 0));
        end
    endtask

    initial begin
        rst       = 1'b1;
        cfg_h     = '0;
        cfg_h_we  = 1'b0;
        cfg_v     = '0;
        cfg_v_we  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        test_reset();
        test_exact();
        test_cut();
        test_cfg_midop();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
